// File: rtl/result_drain.sv
// result_drain: streams a contiguous, wrapping run of output-buffer entries to
// the host over valid/ready. A small credit-controlled FIFO absorbs the
// buffer's 1-cycle read latency so the stream sustains one beat per cycle.
module result_drain #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] op_buf_addr,
    output logic              op_buf_rd,
    input  logic [DATA_W-1:0] op_buf_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CRD_W = OCC_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   beats;
    logic               inflight;

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;

    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count_clamped;
    logic [CRD_W-1:0]   credit_used;
    logic               can_issue;
    logic [CNT_W-1:0]   beats_next;

    // Requests larger than the buffer drain the whole buffer once.
    assign count_clamped = (count > CNT_W'(NUM_ENTRIES)) ? CNT_W'(NUM_ENTRIES) : count;

    // FIFO handshake: returning read data is pushed, host handshake pops.
    assign push = inflight;
    assign pop  = m_valid & m_ready;

    // Stream view of the FIFO head; m_last marks beat number count-1.
    assign m_valid = (occ != '0);
    assign m_data  = mem[rd_ptr];
    assign m_last  = m_valid && (beats == cnt_q - CNT_W'(1));

    // Credits cover stored entries, the read returning now and the read
    // strobed this cycle; a same-cycle pop is deliberately not credited.
    assign credit_used = CRD_W'(occ) + CRD_W'(inflight) + CRD_W'(op_buf_rd);
    assign can_issue   = (issued < cnt_q) && (credit_used < CRD_W'(FIFO_DEPTH));
    assign beats_next  = beats + CNT_W'(pop);

    // Control FSM with registered read strobe/address, busy and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            issued      <= '0;
            beats       <= '0;
            op_buf_rd   <= 1'b0;
            op_buf_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done  <= 1'b0;
            beats <= beats_next;
            case (state)
                IDLE: begin
                    op_buf_rd <= 1'b0;
                    if (start) begin
                        base_q <= base_addr;
                        cnt_q  <= count_clamped;
                        beats  <= '0;
                        if (count_clamped == '0) begin
                            issued <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            // First read goes out in the very next cycle.
                            op_buf_rd   <= 1'b1;
                            op_buf_addr <= base_addr;
                            issued      <= CNT_W'(1);
                            busy        <= 1'b1;
                            state       <= READ;
                        end
                    end
                end
                READ: begin
                    if (can_issue) begin
                        op_buf_rd   <= 1'b1;
                        op_buf_addr <= base_q + ADDR_W'(issued);
                        issued      <= issued + CNT_W'(1);
                    end else begin
                        op_buf_rd <= 1'b0;
                    end
                    if (issued == cnt_q) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    op_buf_rd <= 1'b0;
                    // All beats handshaken implies FIFO empty and nothing in flight.
                    if (beats_next == cnt_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    op_buf_rd <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    op_buf_rd <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Read-return pipeline flag and skid FIFO storage/pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            inflight <= op_buf_rd;
            if (push) begin
                mem[wr_ptr] <= op_buf_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule
